stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Generates the 14-bit display value consumed by the 4-digit FND timewatch driver (top_timeWatch, via its i_fndData port).
- Implements a stopwatch counting hundredths of a second, 00.00 to 99.99, encoded as a binary 0..9999.
- Controlled by two pushbuttons: run/stop and lap/clear.
- Lap mode freezes the displayed value while counting continues.

Parameters:
- CLK_HZ, 100_000_000, sysclk frequency in Hz.
- TICK_HZ, 100, count increment rate in Hz; DIV = CLK_HZ/TICK_HZ, required integer ≥ 2.
- MAX_COUNT, 9999, last value before wrap to 0.

Ports:
- sysclk  input  1  system clock, all logic on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_btnRunStop  input  1  run/stop button, asynchronous level, already debounced, active-high.
- i_btnLapClear  input  1  lap/clear button, asynchronous level, already debounced, active-high.
- o_fndData  output  14  display value 0..9999 (seconds*100 + centiseconds), registered.
- o_running  output  1  high in RUN or LAP.
- o_lap  output  1  high in LAP.

Behaviour:
- Reset
  - Asynchronous, active-low, single clock domain sysclk.
  - While i_rst_n=0: state=IDLE, count=0, prescaler=0, lap register=0, synchronizers=0, all outputs 0.
  - Reset mid-run discards everything; no press is remembered across reset.
- Button input
  - Each button passes through a 2-FF synchronizer, then rising-edge detect, giving a 1-cycle pulse (rs_p, lc_p).
  - Pulse is asserted 3 sysclk edges after the input rises.
  - A held button produces exactly one pulse.
- Prescaler
  - Counts 0..DIV-1 while state is RUN or LAP; tick=1 for one cycle when prescaler=DIV-1, then wraps to 0.
  - Holds its value in PAUSE.
  - Forced to 0 in IDLE.
- Counter
  - On tick: count <= (count==MAX_COUNT) ? 0 : count+1.
  - No carry/overflow flag; wrap is silent.
- State machine (encoding in package): IDLE, RUN, PAUSE, LAP.
  - IDLE: rs_p -> RUN. lc_p ignored.
  - RUN: rs_p -> PAUSE. lc_p -> LAP; lap register <= current count register value (pre-increment if tick fires in the same cycle).
  - LAP: lc_p -> RUN (display released). rs_p -> PAUSE (display returns to live count). Counting continues throughout.
  - PAUSE: rs_p -> RUN, prescaler resumes from its held value. lc_p -> IDLE; count and prescaler cleared to 0 on that edge.
  - Simultaneous rs_p and lc_p in any state: rs_p takes priority, lc_p dropped.
- Outputs
  - o_fndData registered: lap register when state (next) is LAP, otherwise count (next value).
  - o_fndData equals the count/lap value one cycle after it changes (1-cycle latency).
  - o_running and o_lap are registered decodes of state.
  - o_fndData never exceeds MAX_COUNT.

Decomposition:
- Package stopwatch_pkg holds:
  - state enum/localparams: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, LAP=2'd3;
  - CNT_W=14;
  - a DIV-width helper function (clog2 of DIV).
- Sub-module btn_edge_sync: 2-FF synchronizer plus rising-edge pulse, same sysclk/i_rst_n, instantiated once per button.
- Prescaler, counter and FSM remain in stopwatch_core.

Test Plan (CLK_HZ=1000, TICK_HZ=100, so DIV=10; sysclk period 10 ns):
1. Reset then idle: hold i_rst_n=0 for 100 ns, release, wait 500 cycles -> o_fndData=0, o_running=0, o_lap=0 throughout.
2. Run: pulse i_btnRunStop for 3 cycles, wait 1000 cycles -> o_fndData=100±1; increments exactly every 10 cycles; one press yields one state change.
3. Pause/resume/clear:
   - stop at count 57 -> value holds 57 for 200 cycles;
   - press run/stop -> resumes, reaches 58 after the remaining prescaler cycles;
   - stop, then press lap/clear -> IDLE, o_fndData=0.
4. Lap:
   - at count 250, press lap/clear -> o_fndData freezes at 250, o_lap=1;
   - after 300 cycles press lap/clear -> o_fndData ≈280, o_lap=0.
5. Wrap and priority:
   - preload by running to 9998 (force or long run), then 20 cycles -> o_fndData 9998, 9999, 0;
   - assert both buttons on the same cycle in RUN -> PAUSE, not LAP.
6. Async reset mid-operation: assert i_rst_n=0 between clock edges while in LAP with count 4321 -> all outputs 0 immediately, before the next sysclk edge; state IDLE after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//   Shared types and constants for the stopwatch core.
//   - sw_state_t : controller state encoding (IDLE/RUN/PAUSE/LAP)
//   - CNT_W      : width of the display count (0..9999 fits in 14 bits)
//   - div_width  : bit width needed for a prescaler counting 0..div-1
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  localparam int unsigned CNT_W = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  // Bits needed to hold 0..div-1; never less than one bit.
  function automatic int unsigned div_width(input int unsigned div);
    if (div < 2) begin
      return 1;
    end
    return $clog2(div);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// -----------------------------------------------------------------------------
// btn_edge_sync
//   Brings an asynchronous, already-debounced button level into the sysclk
//   domain through a 2-FF synchronizer and emits a single-cycle pulse on each
//   rising edge. The pulse is registered, so it appears 3 sysclk edges after
//   the button rises; holding the button yields exactly one pulse.
//
// Ports
//   sysclk   in  system clock (rising edge)
//   i_rst_n  in  asynchronous active-low reset
//   btn      in  asynchronous button level, active-high
//   pulse    out one-cycle pulse per button press
// -----------------------------------------------------------------------------
module btn_edge_sync (
  input  logic sysclk,
  input  logic i_rst_n,
  input  logic btn,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= btn;
      sync   <= meta;
      sync_d <= sync;
      pulse  <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
//   Hundredths-of-a-second stopwatch producing the binary display value
//   (0..MAX_COUNT, i.e. seconds*100 + centiseconds) for the 4-digit FND driver.
//   Two buttons: run/stop and lap/clear. Lap freezes the display while the
//   count keeps running.
//
// Parameters
//   CLK_HZ    sysclk frequency in Hz
//   TICK_HZ   count increment rate in Hz (CLK_HZ/TICK_HZ must be an integer >= 2)
//   MAX_COUNT last count value before wrapping to 0
//
// Ports
//   sysclk         in  system clock
//   i_rst_n        in  asynchronous active-low reset
//   i_btnRunStop   in  run/stop button level (debounced, async)
//   i_btnLapClear  in  lap/clear button level (debounced, async)
//   o_fndData      out registered display value
//   o_running      out high in RUN or LAP
//   o_lap          out high in LAP
// -----------------------------------------------------------------------------
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned MAX_COUNT = 9999
) (
  input  logic             sysclk,
  input  logic             i_rst_n,
  input  logic             i_btnRunStop,
  input  logic             i_btnLapClear,
  output logic [CNT_W-1:0] o_fndData,
  output logic             o_running,
  output logic             o_lap
);

  localparam int unsigned          DIV        = CLK_HZ / TICK_HZ;
  localparam int unsigned          PRESC_W    = div_width(DIV);
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(MAX_COUNT);

  // ---------------------------------------------------------------------------
  // Button synchronizers
  // ---------------------------------------------------------------------------
  logic rs_p;
  logic lc_p;
  logic lc_act;

  btn_edge_sync u_sync_rs (
    .sysclk  (sysclk),
    .i_rst_n (i_rst_n),
    .btn     (i_btnRunStop),
    .pulse   (rs_p)
  );

  btn_edge_sync u_sync_lc (
    .sysclk  (sysclk),
    .i_rst_n (i_rst_n),
    .btn     (i_btnLapClear),
    .pulse   (lc_p)
  );

  // Run/stop wins when both pulses land in the same cycle.
  assign lc_act = lc_p & ~rs_p;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  sw_state_t          state;
  sw_state_t          state_next;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_next;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [CNT_W-1:0]   lap_val;
  logic [CNT_W-1:0]   lap_next;
  logic               counting;
  logic               tick;
  logic               clear;

  logic [CNT_W-1:0]   fnd_next;
  logic               running_next;
  logic               lap_flag_next;

  // State register
  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rs_p) state_next = RUN;
      end
      RUN: begin
        if (rs_p)        state_next = PAUSE;
        else if (lc_act) state_next = LAP;
      end
      LAP: begin
        if (rs_p)        state_next = PAUSE;
        else if (lc_act) state_next = RUN;
      end
      PAUSE: begin
        if (rs_p)        state_next = RUN;
        else if (lc_act) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Prescaler, count and lap capture. Decisions use the current state, so the
  // edge that leaves RUN/LAP still advances the prescaler/count once, and the
  // edge that leaves PAUSE for RUN keeps the held prescaler value.
  always_comb begin
    counting   = (state == RUN) || (state == LAP);
    tick       = counting && (presc == PRESC_LAST);
    clear      = (state == PAUSE) && lc_act;
    presc_next = presc;
    count_next = count;
    lap_next   = lap_val;

    if ((state == IDLE) || clear) begin
      presc_next = '0;
      count_next = '0;
    end else if (counting) begin
      presc_next = tick ? '0 : presc + 1'b1;
      if (tick) begin
        count_next = (count == CNT_LAST) ? '0 : count + 1'b1;
      end
    end

    // Lap captures the pre-increment count.
    if ((state == RUN) && lc_act) begin
      lap_next = count;
    end
  end

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc   <= '0;
      count   <= '0;
      lap_val <= '0;
    end else begin
      presc   <= presc_next;
      count   <= count_next;
      lap_val <= lap_next;
    end
  end

  // Output decode from next values so the registered outputs track the
  // count/lap with a single cycle of latency.
  always_comb begin
    fnd_next      = (state_next == LAP) ? lap_next : count_next;
    running_next  = (state_next == RUN) || (state_next == LAP);
    lap_flag_next = (state_next == LAP);
  end

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fndData <= '0;
      o_running <= 1'b0;
      o_lap     <= 1'b0;
    end else begin
      o_fndData <= fnd_next;
      o_running <= running_next;
      o_lap     <= lap_flag_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_core
//   Directed bench. dut1 runs with DIV=10 for the main scenarios; dut2 runs
//   with DIV=2 so the 9999 -> 0 wrap and the mid-LAP reset at 4321 are reached
//   in a modest number of cycles.
// -----------------------------------------------------------------------------
module tb_stopwatch_core;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        rs1 = 1'b0, lc1 = 1'b0;
  logic        rs2 = 1'b0, lc2 = 1'b0;
  logic [13:0] fnd1, fnd2;
  logic        run1, run2, lap1, lap2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 sysclk = ~sysclk;

  stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .MAX_COUNT(9999)) dut1 (
    .sysclk        (sysclk),
    .i_rst_n       (rst_n),
    .i_btnRunStop  (rs1),
    .i_btnLapClear (lc1),
    .o_fndData     (fnd1),
    .o_running     (run1),
    .o_lap         (lap1)
  );

  stopwatch_core #(.CLK_HZ(200), .TICK_HZ(100), .MAX_COUNT(9999)) dut2 (
    .sysclk        (sysclk),
    .i_rst_n       (rst_n),
    .i_btnRunStop  (rs2),
    .i_btnLapClear (lc2),
    .o_fndData     (fnd2),
    .o_running     (run2),
    .o_lap         (lap2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge sysclk);
  endtask

  // Holds the selected buttons for 3 cycles; the state change happens on the
  // first rising edge after this task returns.
  task automatic press(input int unsigned d, input logic rs, input logic lc);
    @(negedge sysclk);
    if (d == 1) begin rs1 = rs; lc1 = lc; end
    else        begin rs2 = rs; lc2 = lc; end
    repeat (3) @(negedge sysclk);
    if (d == 1) begin rs1 = 1'b0; lc1 = 1'b0; end
    else        begin rs2 = 1'b0; lc2 = 1'b0; end
  endtask

  initial begin
    // 1. Reset then idle
    wait_cyc(5);
    chk("rst_fnd", 32'(fnd1), 0);
    chk("rst_run", 32'(run1), 0);
    chk("rst_lap", 32'(lap1), 0);
    wait_cyc(5);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_cyc(50);
      chk("idle_fnd", 32'(fnd1), 0);
      chk("idle_run", 32'(run1), 0);
      chk("idle_lap", 32'(lap1), 0);
    end

    // 2. Run: count k appears after 10k edges past the action edge
    press(1, 1'b1, 1'b0);
    wait_cyc(1);
    chk("run_start_run", 32'(run1), 1);
    chk("run_start_fnd", 32'(fnd1), 0);
    chk("run_start_lap", 32'(lap1), 0);
    wait_cyc(1000);
    chk("run_1001", 32'(fnd1), 100);
    wait_cyc(9);
    chk("run_1010", 32'(fnd1), 100);
    wait_cyc(1);
    chk("run_1011", 32'(fnd1), 101);
    press(1, 1'b1, 1'b0);
    press(1, 1'b0, 1'b1);
    wait_cyc(1);
    chk("clr2_fnd", 32'(fnd1), 0);
    chk("clr2_run", 32'(run1), 0);

    // 3. Pause at 57 with prescaler 5, resume, clear
    press(1, 1'b1, 1'b0);
    wait_cyc(571);
    press(1, 1'b1, 1'b0);
    wait_cyc(1);
    chk("pause_fnd", 32'(fnd1), 57);
    chk("pause_run", 32'(run1), 0);
    wait_cyc(199);
    chk("pause_hold", 32'(fnd1), 57);
    press(1, 1'b1, 1'b0);
    wait_cyc(5);
    chk("resume_57", 32'(fnd1), 57);
    chk("resume_run", 32'(run1), 1);
    wait_cyc(1);
    chk("resume_58", 32'(fnd1), 58);
    press(1, 1'b1, 1'b0);
    press(1, 1'b0, 1'b1);
    wait_cyc(1);
    chk("clr3_fnd", 32'(fnd1), 0);
    chk("clr3_run", 32'(run1), 0);

    // 4. Lap at 250, release 305 cycles later at 281
    press(1, 1'b1, 1'b0);
    wait_cyc(2501);
    press(1, 1'b0, 1'b1);
    wait_cyc(1);
    chk("lap_fnd", 32'(fnd1), 250);
    chk("lap_flag", 32'(lap1), 1);
    chk("lap_run", 32'(run1), 1);
    wait_cyc(300);
    chk("lap_frozen", 32'(fnd1), 250);
    press(1, 1'b0, 1'b1);
    wait_cyc(1);
    chk("unlap_fnd", 32'(fnd1), 281);
    chk("unlap_flag", 32'(lap1), 0);
    chk("unlap_run", 32'(run1), 1);

    // 5. Wrap on dut2 (DIV=2): count k appears 2k edges past the action edge
    press(2, 1'b1, 1'b0);
    wait_cyc(19996);
    chk("wrap_9997", 32'(fnd2), 9997);
    wait_cyc(1);
    chk("wrap_9998", 32'(fnd2), 9998);
    wait_cyc(2);
    chk("wrap_9999a", 32'(fnd2), 9999);
    wait_cyc(1);
    chk("wrap_9999b", 32'(fnd2), 9999);
    wait_cyc(1);
    chk("wrap_0", 32'(fnd2), 0);
    wait_cyc(2);
    chk("wrap_1", 32'(fnd2), 1);
    // Both buttons together in RUN: run/stop wins -> PAUSE
    press(2, 1'b1, 1'b1);
    wait_cyc(1);
    chk("prio_run", 32'(run2), 0);
    chk("prio_lap", 32'(lap2), 0);
    chk("prio_fnd", 32'(fnd2), 3);
    wait_cyc(10);
    chk("prio_hold", 32'(fnd2), 3);

    // 6. Resume, lap at 4321, async reset between edges
    press(2, 1'b1, 1'b0);
    wait_cyc(8632);
    press(2, 1'b0, 1'b1);
    wait_cyc(1);
    chk("lap2_fnd", 32'(fnd2), 4321);
    chk("lap2_flag", 32'(lap2), 1);
    wait_cyc(20);
    chk("lap2_frozen", 32'(fnd2), 4321);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fnd2", 32'(fnd2), 0);
    chk("arst_run2", 32'(run2), 0);
    chk("arst_lap2", 32'(lap2), 0);
    chk("arst_fnd1", 32'(fnd1), 0);
    chk("arst_run1", 32'(run1), 0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(20);
    chk("post_fnd", 32'(fnd2), 0);
    chk("post_run", 32'(run2), 0);
    press(2, 1'b0, 1'b1);
    wait_cyc(20);
    chk("idle_lc_run", 32'(run2), 0);
    chk("idle_lc_lap", 32'(lap2), 0);
    press(2, 1'b1, 1'b0);
    wait_cyc(1);
    chk("restart_run", 32'(run2), 1);
    chk("restart_fnd", 32'(fnd2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
